// File: rtl/ascon_ti_io_sequencer_pkg.sv
// Shared definitions for the threshold-implementation Ascon I/O sequencer:
// sequencer states, default operand geometry and a share-slice helper.
package ascon_ti_pkg;

   localparam int DATA_W = 128;
   localparam int SHARES = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_LAUNCH,
      ST_WAIT,
      ST_STORE,
      ST_FINISH
   } state_t;

   // Returns the share-s word of a share bus laid out as {share4, ..., share0}.
   function automatic logic [DATA_W-1:0] share_slice(input logic [SHARES*DATA_W-1:0] bus,
                                                     input int unsigned s);
      return bus[s*DATA_W +: DATA_W];
   endfunction

endpackage

// File: rtl/ascon_ti_io_sequencer_unmask.sv
// Recombines pSHARES Boolean shares of one operand bit into its plain value.
module ascon_ti_share_unmask
   import ascon_ti_pkg::*;
#(
   parameter int pDATA_WIDTH = DATA_W,
   parameter int pSHARES     = SHARES,
   parameter int pIDX_WIDTH  = $clog2(pDATA_WIDTH)
) (
   input  logic [pSHARES*pDATA_WIDTH-1:0] shares,
   input  logic [pIDX_WIDTH-1:0]          bit_sel,
   output logic                           bit_out
);

   logic [pDATA_WIDTH-1:0] share_w [pSHARES];

   for (genvar g = 0; g < pSHARES; g++) begin : g_split
      assign share_w[g] = shares[g*pDATA_WIDTH +: pDATA_WIDTH];
   end

   // XOR-reduce the selected bit across every share.
   always_comb begin
      bit_out = 1'b0;
      for (int s = 0; s < pSHARES; s++) begin
         bit_out = bit_out ^ share_w[s][bit_sel];
      end
   end

endmodule

// File: rtl/ascon_ti_io_sequencer.sv
// Loads masked operands bit by bit from the register block, launches the
// TI Ascon core, then unmasks ciphertext and tag and writes them back.
module ascon_ti_io_sequencer
   import ascon_ti_pkg::*;
#(
   parameter int pDATA_WIDTH = DATA_W,
   parameter int pSHARES     = SHARES,
   parameter int pADDR_WIDTH = 12,
   parameter int pRD_LAT     = 1,
   parameter int pTIMEOUT    = 4096
) (
   input  logic                           crypto_clk,
   input  logic                           reset_n,
   input  logic                           start,
   input  logic [pSHARES-1:0]             kin_word,
   input  logic [pSHARES-1:0]             nin_word,
   input  logic [pSHARES-1:0]             adin_word,
   input  logic [pSHARES-1:0]             ptin_word,
   output logic [pADDR_WIDTH-1:0]         w_addr,
   output logic                           w_en,
   output logic                           out_word,
   output logic                           tagout_word,
   output logic [pSHARES*pDATA_WIDTH-1:0] key_sh,
   output logic [pSHARES*pDATA_WIDTH-1:0] nonce_sh,
   output logic [pSHARES*pDATA_WIDTH-1:0] ad_sh,
   output logic [pSHARES*pDATA_WIDTH-1:0] pt_sh,
   output logic                           core_start,
   input  logic                           core_done,
   input  logic [pSHARES*pDATA_WIDTH-1:0] ct_sh,
   input  logic [pSHARES*pDATA_WIDTH-1:0] tag_sh,
   output logic                           ready,
   output logic                           busy,
   output logic                           done,
   output logic                           timeout_err
);

   localparam int AW = $clog2(pDATA_WIDTH) + 1;
   localparam int IW = $clog2(pDATA_WIDTH);
   localparam int TW = $clog2(pTIMEOUT);
   localparam logic [AW-1:0] LAST_ADDR = AW'(pDATA_WIDTH - 1);
   localparam logic [TW-1:0] LAST_WAIT = TW'(pTIMEOUT - 1);

   state_t                 state, state_next;
   logic [AW-1:0]          addr_cnt;
   logic                   drain_q;
   logic [pRD_LAT-1:0]     pipe_vld;
   logic [AW-1:0]          pipe_addr [pRD_LAT];
   logic                   done_q, done_edge, last_capture;
   logic [IW-1:0]          cap_idx, store_idx;
   logic [TW-1:0]          wait_cnt;
   logic                   ct_bit, tag_bit;
   logic [pDATA_WIDTH-1:0] key_q [pSHARES];
   logic [pDATA_WIDTH-1:0] nonce_q [pSHARES];
   logic [pDATA_WIDTH-1:0] ad_q [pSHARES];
   logic [pDATA_WIDTH-1:0] pt_q [pSHARES];

   assign done_edge    = core_done & ~done_q;
   assign last_capture = pipe_vld[pRD_LAT-1] && (pipe_addr[pRD_LAT-1] == LAST_ADDR);
   assign cap_idx      = LAST_ADDR[IW-1:0] - pipe_addr[pRD_LAT-1][IW-1:0];
   assign store_idx    = LAST_ADDR[IW-1:0] - addr_cnt[IW-1:0];
   assign w_addr       = pADDR_WIDTH'(addr_cnt);
   assign ready        = (state == ST_IDLE);
   assign busy         = (state != ST_IDLE);
   assign out_word     = w_en & ct_bit;
   assign tagout_word  = w_en & tag_bit;

   for (genvar g = 0; g < pSHARES; g++) begin : g_flat
      assign key_sh[g*pDATA_WIDTH +: pDATA_WIDTH]   = key_q[g];
      assign nonce_sh[g*pDATA_WIDTH +: pDATA_WIDTH] = nonce_q[g];
      assign ad_sh[g*pDATA_WIDTH +: pDATA_WIDTH]    = ad_q[g];
      assign pt_sh[g*pDATA_WIDTH +: pDATA_WIDTH]    = pt_q[g];
   end

   ascon_ti_share_unmask #(.pDATA_WIDTH(pDATA_WIDTH), .pSHARES(pSHARES), .pIDX_WIDTH(IW)) u_ct_unmask (
      .shares (ct_sh),
      .bit_sel(store_idx),
      .bit_out(ct_bit)
   );

   ascon_ti_share_unmask #(.pDATA_WIDTH(pDATA_WIDTH), .pSHARES(pSHARES), .pIDX_WIDTH(IW)) u_tag_unmask (
      .shares (tag_sh),
      .bit_sel(store_idx),
      .bit_out(tag_bit)
   );

   // State register.
   always_ff @(posedge crypto_clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   // Next-state decode; a core_done edge beats a simultaneous timeout.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (start) state_next = ST_LOAD;
         ST_LOAD:   if (last_capture) state_next = ST_LAUNCH;
         ST_LAUNCH: state_next = ST_WAIT;
         ST_WAIT: begin
            if (done_edge)                  state_next = ST_STORE;
            else if (wait_cnt == LAST_WAIT) state_next = ST_FINISH;
         end
         ST_STORE:  if (addr_cnt == LAST_ADDR) state_next = ST_FINISH;
         ST_FINISH: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // core_done history, sampled in every state so a level held on WAIT entry is not an edge.
   always_ff @(posedge crypto_clk or negedge reset_n) begin
      if (!reset_n) done_q <= 1'b0;
      else          done_q <= core_done;
   end

   // Address walk, read-latency pipeline, wait counter and registered strobes.
   always_ff @(posedge crypto_clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_cnt    <= '0;
         drain_q     <= 1'b0;
         wait_cnt    <= '0;
         w_en        <= 1'b0;
         core_start  <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         pipe_vld    <= '0;
         for (int i = 0; i < pRD_LAT; i++) pipe_addr[i] <= '0;
      end else begin
         w_en         <= (state_next == ST_STORE);
         core_start   <= (state_next == ST_LAUNCH);
         done         <= (state_next == ST_FINISH);
         pipe_vld[0]  <= (state == ST_LOAD) && !drain_q;
         pipe_addr[0] <= addr_cnt;
         for (int i = 1; i < pRD_LAT; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_addr[i] <= pipe_addr[i-1];
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  timeout_err <= 1'b0;
                  addr_cnt    <= '0;
                  drain_q     <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (!drain_q) begin
                  if (addr_cnt == LAST_ADDR) drain_q  <= 1'b1;
                  else                       addr_cnt <= addr_cnt + AW'(1);
               end
            end
            ST_LAUNCH: wait_cnt <= '0;
            ST_WAIT: begin
               wait_cnt <= wait_cnt + TW'(1);
               if (state_next == ST_STORE) begin
                  addr_cnt <= '0;
               end else if (state_next == ST_FINISH) begin
                  timeout_err <= 1'b1;
                  addr_cnt    <= '0;
               end
            end
            ST_STORE: begin
               if (state_next == ST_FINISH) addr_cnt <= '0;
               else                         addr_cnt <= addr_cnt + AW'(1);
            end
            ST_FINISH: addr_cnt <= '0;
            default:   addr_cnt <= '0;
         endcase
      end
   end

   // Mask each captured word: share0 carries d^r0^..^r3, share s carries r(s-1).
   always_ff @(posedge crypto_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < pSHARES; s++) begin
            key_q[s]   <= '0;
            nonce_q[s] <= '0;
            ad_q[s]    <= '0;
            pt_q[s]    <= '0;
         end
      end else if (pipe_vld[pRD_LAT-1] && (state == ST_LOAD)) begin
         key_q[0][cap_idx]   <= ^kin_word;
         nonce_q[0][cap_idx] <= ^nin_word;
         ad_q[0][cap_idx]    <= ^adin_word;
         pt_q[0][cap_idx]    <= ^ptin_word;
         for (int s = 1; s < pSHARES; s++) begin
            key_q[s][cap_idx]   <= kin_word[s];
            nonce_q[s][cap_idx] <= nin_word[s];
            ad_q[s][cap_idx]    <= adin_word[s];
            pt_q[s][cap_idx]    <= ptin_word[s];
         end
      end
   end

endmodule

// File: tb/tb_ascon_ti_io_sequencer.sv
// Scoreboard bench for the TI Ascon I/O sequencer: a word memory and a core
// model feed the DUT, expected stores and completions are queued per
// operation and a monitor pops them as the DUT presents w_en and done.
module tb_ascon_ti_io_sequencer;
   import ascon_ti_pkg::*;

   localparam int DW  = 128;
   localparam int NS  = 5;
   localparam int BW  = NS * DW;
   localparam int TMO = 64;

   logic            crypto_clk = 1'b0;
   logic            reset_n    = 1'b0;
   logic            start      = 1'b0;
   logic            core_done  = 1'b0;
   logic [NS-1:0]   kin_word = '0, nin_word = '0, adin_word = '0, ptin_word = '0;
   logic [11:0]     w_addr;
   logic            w_en, out_word, tagout_word, core_start, ready, busy, done, timeout_err;
   logic [BW-1:0]   key_sh, nonce_sh, ad_sh, pt_sh;
   logic [BW-1:0]   ct_drv = '0, tag_drv = '0;

   typedef struct { logic [11:0] addr; logic ct; logic tg; } store_t;
   typedef struct { logic terr; logic [BW-1:0] k, n, a, p; } fin_t;

   store_t       exp_store[$];
   fin_t         exp_done[$];
   logic [NS-1:0] mem [4][DW];

   int n_cmp = 0, n_bad = 0;
   int cyc = 0;
   int core_delay = 20;
   int cs_count = 0, cs_cyc = 0, done_count = 0, last_wen_cyc = -10;

   ascon_ti_io_sequencer #(.pTIMEOUT(TMO)) dut (
      .crypto_clk (crypto_clk),
      .reset_n    (reset_n),
      .start      (start),
      .kin_word   (kin_word),
      .nin_word   (nin_word),
      .adin_word  (adin_word),
      .ptin_word  (ptin_word),
      .w_addr     (w_addr),
      .w_en       (w_en),
      .out_word   (out_word),
      .tagout_word(tagout_word),
      .key_sh     (key_sh),
      .nonce_sh   (nonce_sh),
      .ad_sh      (ad_sh),
      .pt_sh      (pt_sh),
      .core_start (core_start),
      .core_done  (core_done),
      .ct_sh      (ct_drv),
      .tag_sh     (tag_drv),
      .ready      (ready),
      .busy       (busy),
      .done       (done),
      .timeout_err(timeout_err)
   );

   // Free-running clock and cycle counter.
   always #5 crypto_clk = ~crypto_clk;
   always @(posedge crypto_clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [BW-1:0] actual, input logic [BW-1:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Reference masking: gather data and random planes, then share0 = d ^ all randoms.
   function automatic logic [BW-1:0] build_shares(input int op);
      logic [DW-1:0] d, r0, r1, r2, r3;
      for (int a = 0; a < DW; a++) begin
         d[DW-1-a]  = mem[op][a][0];
         r0[DW-1-a] = mem[op][a][1];
         r1[DW-1-a] = mem[op][a][2];
         r2[DW-1-a] = mem[op][a][3];
         r3[DW-1-a] = mem[op][a][4];
      end
      return {r3, r2, r1, r0, d ^ r0 ^ r1 ^ r2 ^ r3};
   endfunction

   function automatic logic [DW-1:0] plain_of(input logic [BW-1:0] bus);
      logic [DW-1:0] acc = '0;
      for (int s = 0; s < NS; s++) acc ^= share_slice(bus, s);
      return acc;
   endfunction

   function automatic logic [BW-1:0] rand_bus();
      logic [BW-1:0] v;
      for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Register-block model: the word for an address appears one cycle after w_addr shows it.
   initial begin : word_driver
      int prev;
      prev = 0;
      forever begin
         @(negedge crypto_clk);
         kin_word  = mem[0][prev];
         nin_word  = mem[1][prev];
         adin_word = mem[2][prev];
         ptin_word = mem[3][prev];
         prev      = int'(w_addr[6:0]);
      end
   end

   // Core model: counts launches and raises core_done for a few cycles after core_delay.
   initial begin : core_model
      forever begin
         @(negedge crypto_clk);
         if (core_start === 1'b1) begin
            cs_count++;
            cs_cyc = cyc;
            if (core_delay >= 0) begin
               repeat (core_delay) @(negedge crypto_clk);
               core_done = 1'b1;
               repeat (3) @(negedge crypto_clk);
               core_done = 1'b0;
            end
         end
      end
   end

   // Monitor: pops expected stores on w_en and expected completions on done.
   initial begin : monitor
      store_t se;
      fin_t   de;
      forever begin
         @(negedge crypto_clk);
         if (reset_n === 1'b1) begin
            if (w_en === 1'b1) begin
               last_wen_cyc = cyc;
               if (exp_store.size() == 0) begin
                  checkOutput("w_en_unexpected", BW'(w_en), BW'(0));
               end else begin
                  se = exp_store.pop_front();
                  checkOutput("store_addr", BW'(w_addr), BW'(se.addr));
                  checkOutput("out_word", BW'(out_word), BW'(se.ct));
                  checkOutput("tagout_word", BW'(tagout_word), BW'(se.tg));
               end
            end
            if (done === 1'b1) begin
               done_count++;
               if (exp_done.size() == 0) begin
                  checkOutput("done_unexpected", BW'(done), BW'(0));
               end else begin
                  de = exp_done.pop_front();
                  checkOutput("timeout_err_at_done", BW'(timeout_err), BW'(de.terr));
                  checkOutput("key_sh", key_sh, de.k);
                  checkOutput("nonce_sh", nonce_sh, de.n);
                  checkOutput("ad_sh", ad_sh, de.a);
                  checkOutput("pt_sh", pt_sh, de.p);
                  if (!de.terr) checkOutput("done_after_last_wen", BW'(cyc - last_wen_cyc), BW'(1));
               end
            end
         end
      end
   end

   // One operation: fill memories, queue expectations, pulse start, wait for completion.
   task automatic applyStimulus(input int delay, input bit extra_starts, input bit pattern);
      fin_t          de;
      store_t        se;
      logic [DW-1:0] ct_plain, tag_plain;
      int t0, cs0, d0, cs_k, viol, prev_wa;
      bit cs_seen;
      for (int op = 0; op < 4; op++)
         for (int a = 0; a < DW; a++) mem[op][a] = NS'($urandom);
      ct_drv  = rand_bus();
      tag_drv = rand_bus();
      if (pattern) begin
         for (int a = 0; a < DW; a++) mem[0][a] = 5'b10101;
         ct_drv = '0;
         ct_drv[DW-1:0] = 128'h0123456789ABCDEF0123456789ABCDEF;
      end
      core_delay = delay;
      de.terr = (delay < 0);
      de.k = build_shares(0);
      de.n = build_shares(1);
      de.a = build_shares(2);
      de.p = build_shares(3);
      exp_done.push_back(de);
      ct_plain  = plain_of(ct_drv);
      tag_plain = plain_of(tag_drv);
      if (delay >= 0) begin
         for (int a = 0; a < DW; a++) begin
            se.addr = 12'(a);
            se.ct   = ct_plain[DW-1-a];
            se.tg   = tag_plain[DW-1-a];
            exp_store.push_back(se);
         end
      end
      @(negedge crypto_clk);
      start = 1'b1;
      @(negedge crypto_clk);
      start = 1'b0;
      t0  = cyc;
      cs0 = cs_count;
      d0  = done_count;
      checkOutput("busy_after_start", BW'({ready, busy}), BW'(2'b01));
      checkOutput("timeout_err_cleared", BW'(timeout_err), BW'(0));
      cs_seen = 1'b0;
      cs_k = 0;
      viol = 0;
      prev_wa = 0;
      for (int k = 1; k < 3000 && done_count == d0; k++) begin
         @(negedge crypto_clk);
         start = 1'b0;
         if (extra_starts && (k == 50 || (cs_seen && k == cs_k + 5))) start = 1'b1;
         if (!cs_seen && cs_count != cs0) begin
            cs_seen = 1'b1;
            cs_k = k;
         end
         if (!cs_seen) begin
            if (int'(w_addr) < prev_wa || int'(w_addr) >= DW) viol++;
            prev_wa = int'(w_addr);
         end
      end
      start = 1'b0;
      repeat (5) @(negedge crypto_clk);
      checkOutput("done_count", BW'(done_count - d0), BW'(1));
      checkOutput("core_start_count", BW'(cs_count - cs0), BW'(1));
      if (cs_count != cs0) checkOutput("core_start_latency", BW'(cs_cyc - t0), BW'(129));
      checkOutput("load_addr_monotonic", BW'(viol), BW'(0));
      checkOutput("ready_after_op", BW'({ready, busy}), BW'(2'b10));
      checkOutput("timeout_err_after_op", BW'(timeout_err), BW'(delay < 0));
      checkOutput("store_queue_drained", BW'(exp_store.size()), BW'(0));
   endtask

   // Directed reset checks and the operation sequence.
   initial begin : main
      logic [DW-1:0] ones;
      logic [BW-1:0] key_pat;
      int            guard;
      ones    = '1;
      key_pat = {ones, {DW{1'b0}}, ones, {DW{1'b0}}, ones};
      for (int op = 0; op < 4; op++)
         for (int a = 0; a < DW; a++) mem[op][a] = '0;

      repeat (3) @(negedge crypto_clk);
      reset_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge crypto_clk);
         checkOutput("reset_state", BW'({ready, busy, w_en, core_start, done, timeout_err, w_addr}),
                     BW'({1'b1, 5'b0, 12'h000}));
         checkOutput("reset_shares", key_sh | nonce_sh | ad_sh | pt_sh, '0);
      end

      $display("[TB] directed pattern operation");
      applyStimulus(20, 1'b0, 1'b1);
      checkOutput("key_pattern_shares", key_sh, key_pat);

      $display("[TB] random operations");
      for (int n = 0; n < 3; n++) applyStimulus(int'($urandom_range(3, 40)), 1'b0, 1'b0);

      $display("[TB] timeout operation");
      applyStimulus(-1, 1'b0, 1'b0);
      applyStimulus(10, 1'b0, 1'b0);

      $display("[TB] start pulses while busy");
      applyStimulus(15, 1'b1, 1'b0);

      $display("[TB] reset during load");
      core_delay = 20;
      for (int op = 0; op < 4; op++)
         for (int a = 0; a < DW; a++) mem[op][a] = NS'($urandom);
      @(negedge crypto_clk);
      start = 1'b1;
      @(negedge crypto_clk);
      start = 1'b0;
      guard = 0;
      while (w_addr != 12'd60 && guard < 300) begin
         @(negedge crypto_clk);
         guard++;
      end
      checkOutput("reached_addr_60", BW'(w_addr), BW'(60));
      reset_n = 1'b0;
      #1;
      checkOutput("async_reset_outputs",
                  BW'({ready, busy, w_en, out_word, tagout_word, core_start, done, timeout_err, w_addr}),
                  BW'({1'b1, 7'b0, 12'h000}));
      checkOutput("async_reset_shares", key_sh | nonce_sh | ad_sh | pt_sh, '0);
      @(negedge crypto_clk);
      reset_n = 1'b1;
      exp_store.delete();
      exp_done.delete();
      applyStimulus(25, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ascon_ti_io_sequencer.md
Name: ascon_ti_io_sequencer

Overview:
- Sits in the crypto_clk domain between the register block and the threshold-implementation Ascon core.
- On a start pulse it walks the 128 bit addresses, fetches key/nonce/AD/PT words (1 data bit plus 4 random bits each), masks them into 5 shares per bit, and launches the core.
- When the core finishes, it walks the addresses again, unmasks ciphertext and tag bit by bit, and writes them back with w_addr/w_en.
- It also drives ready/busy/done for the host interface.

Parameters:
- pDATA_WIDTH, 128, bits per operand (key, nonce, AD, PT, CT, tag).
- pSHARES, 5, shares per bit (1 data + pSHARES-1 random).
- pADDR_WIDTH, 12, width of w_addr.
- pRD_LAT, 1, crypto_clk cycles from w_addr change to a valid *_word input.
- pTIMEOUT, 4096, maximum cycles spent waiting for core_done.

Ports:
- crypto_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle go request.
- kin_word  in  pSHARES  {r3,r2,r1,r0,d} for the current address; the same format applies to the next three ports.
- nin_word  in  pSHARES  nonce word.
- adin_word  in  pSHARES  AD word.
- ptin_word  in  pSHARES  PT word.
- w_addr  out  pADDR_WIDTH  bit address; address a selects operand bit pDATA_WIDTH-1-a.
- w_en  out  1  write strobe for out_word/tagout_word.
- out_word  out  1  unmasked CT bit for w_addr.
- tagout_word  out  1  unmasked tag bit for w_addr.
- key_sh  out  pSHARES*pDATA_WIDTH  share s occupies [s*pDATA_WIDTH +: pDATA_WIDTH]; the same layout applies to the next three ports.
- nonce_sh  out  pSHARES*pDATA_WIDTH  nonce shares.
- ad_sh  out  pSHARES*pDATA_WIDTH  AD shares.
- pt_sh  out  pSHARES*pDATA_WIDTH  PT shares.
- core_start  out  1  one-cycle launch pulse to the core.
- core_done  in  1  level or pulse from the core; only its rising edge is used.
- ct_sh  in  pSHARES*pDATA_WIDTH  CT shares from the core.
- tag_sh  in  pSHARES*pDATA_WIDTH  tag shares from the core.
- ready  out  1  high in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- timeout_err  out  1  sticky; cleared by the next accepted start.

Behaviour:
- Reset (asynchronous assert, synchronous deassert expected upstream) forces:
  - state IDLE;
  - w_addr=0, w_en=0, out_word=0, tagout_word=0;
  - all *_sh outputs 0;
  - core_start=0, ready=1, busy=0, done=0, timeout_err=0;
  - all counters 0.
- FSM states: IDLE, LOAD, LAUNCH, WAIT, STORE, FINISH.
- IDLE:
  - start=1 moves to LOAD next cycle, clears timeout_err, and sets w_addr=0.
  - start in any other state is ignored.
- LOAD:
  - w_addr increments 0..pDATA_WIDTH-1, one per cycle.
  - A pRD_LAT-deep pipeline of address and valid tracks each request.
  - On a captured word for address a, bit i = pDATA_WIDTH-1-a:
    - share0[i] = d^r0^r1^r2^r3;
    - share s (1..4) [i] = r(s-1).
  - This applies identically to all four operands.
  - Leave LOAD when the last captured word lands, i.e. pDATA_WIDTH+pRD_LAT cycles after entry. w_addr holds at pDATA_WIDTH-1 during drain.
- LAUNCH: core_start=1 for exactly one cycle, then WAIT.
- WAIT:
  - Rising edge of core_done moves to STORE.
  - A core_done level already high on entry does not count. An edge detector register is sampled in every state.
  - A free-running wait counter reaching pTIMEOUT-1 sets timeout_err and goes to FINISH, skipping STORE.
- STORE:
  - w_addr walks 0..pDATA_WIDTH-1 with w_en=1 each cycle.
  - out_word = XOR over s of ct_sh share s bit (pDATA_WIDTH-1-w_addr); tagout_word is formed the same way from tag_sh.
  - Both are combinational on the registered w_addr, so they are valid in the same cycle as w_en.
  - After address pDATA_WIDTH-1: w_en=0, go to FINISH.
- FINISH: done=1 for one cycle, w_addr=0, then IDLE.
- Outputs are registered except out_word/tagout_word. ready and busy are state decodes, mutually exclusive.
- *_sh outputs hold their values after completion until the next LOAD overwrites them. No clearing at FINISH.
- Counter widths:
  - address counter is clog2(pDATA_WIDTH)+1 bits, zero-extended to pADDR_WIDTH;
  - timeout counter is clog2(pTIMEOUT) bits;
  - no wrap-around is reachable.
- Events in the same cycle:
  - core_done edge on the timeout cycle: done wins, go to STORE, no error.
  - start in the same cycle as done: ignored.
  - Reset mid-operation aborts immediately; core_start drops asynchronously.

Decomposition:
- Shared package ascon_ti_pkg holds:
  - the state enum;
  - constants DATA_W=128, SHARES=5;
  - a share-slice helper function that returns the share-s word of a bus.
- One sub-module, ascon_ti_share_unmask, performs bitwise XOR-reduction of pSHARES shares at a selected bit. It is instantiated twice (CT, tag).
- Masking stays inline in LOAD.

Test Plan:
- Reset released, no start -> ready=1, busy=0, w_addr=0, w_en=0, all *_sh=0 for 50 cycles.
- Single op, key bits all 1, random words r=4'b1010 for every address, core model asserting done 20 cycles after core_start:
  - key_sh share0 = all 1^0^1^0^1 = all 1;
  - share1 = all 0, share2 = all 1, share3 = all 0, share4 = all 1;
  - core_start is seen exactly once, 129 cycles after start (pRD_LAT=1).
- STORE with core returning ct share0=128'h0123…CDEF and all other shares 0:
  - 128 consecutive w_en cycles;
  - out_word at w_addr=0 equals bit 127 = 0, at w_addr=127 equals bit 0 = 1;
  - done pulses once, one cycle after the last w_en.
- Timeout, pTIMEOUT=64, core never asserts done -> timeout_err=1, done pulses, w_en never asserts, return to IDLE; the next start clears timeout_err.
- start pulsed again during LOAD and during WAIT -> no restart; w_addr sequence stays monotonic; exactly one done.
- reset_n low for 1 cycle at w_addr=60 during LOAD -> all outputs at reset values in the same cycle; a fresh start then completes normally with correct shares.
